alu_tester: RTL and testbench

ALU_TESTER -- requirements
Module: alu_tester

---
 rtl/alu_tester_pkg.sv | 54 +++++
 rtl/key_debounce.sv | 63 ++++++
 rtl/alu_tester.sv | 214 +++++++++++++++++++++
 tb/tb_alu_tester.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_tester_pkg.sv
// -----------------------------------------------------------------------------
// alu_tester_pkg
// Shared types and constants for the ALU tester board harness:
//   state_t   - controller FSM states; the encodings are the values shown
//               on led[6:4], so they are fixed rather than left to synthesis.
//   page_t    - display page selector (result, A, B, opcode).
//   SEG_TABLE - active-low seven-segment patterns for hex digits 0-F,
//               bit order {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
package alu_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_HAVE_A = 3'b001,
    ST_READY  = 3'b010,
    ST_SHOW   = 3'b011,
    ST_EXEC   = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    PAGE_RESULT = 2'd0,
    PAGE_A      = 2'd1,
    PAGE_B      = 2'd2,
    PAGE_OP     = 2'd3
  } page_t;

  localparam int NUM_KEYS = 4;

  // Key indices into the debounced event vector.
  localparam int KEY_CAPTURE = 0;
  localparam int KEY_NEXT_OP = 1;
  localparam int KEY_EXECUTE = 2;
  localparam int KEY_PAGE    = 3;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One pushbutton conditioner: 2-flop synchronizer, stable-low counter and
// one-shot. press pulses for exactly one cycle once the synchronized key has
// been sampled low for DEB_CYCLES consecutive cycles, and cannot pulse again
// until the key has been sampled high.
//
// Ports:
//   CLK    in  system clock
//   RST    in  asynchronous active-high reset (key treated as released)
//   key_n  in  raw active-low key, asynchronous to CLK
//   press  out one-cycle press event
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fired_reg;
  logic             press_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      cnt_reg   <= '0;
      fired_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg) begin
        // Any high sample breaks the run and re-arms the one-shot.
        cnt_reg   <= '0;
        fired_reg <= 1'b0;
      end else if (!fired_reg) begin
        // cnt_reg holds the number of earlier consecutive low samples, so
        // the DEB_CYCLES-th low sample is the one seen with CNT_LAST.
        if (cnt_reg == CNT_LAST) begin
          press_reg <= 1'b1;
          fired_reg <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/alu_tester.sv
// -----------------------------------------------------------------------------
// alu_tester
// Board harness for exercising an external combinational ALU from four
// pushbuttons and a bank of switches. Operands A and B are captured from the
// switches (zero- or one-filled to DATA_W), an opcode is stepped with a key,
// and an execute key runs one EXEC cycle whose edge latches the ALU result
// and flags. Seven-segment digits show a selectable page.
//
// Ports:
//   CLK           in  system clock, rising edge
//   RST           in  asynchronous active-high reset
//   key_n[3:0]    in  raw active-low keys: 0 capture, 1 next op,
//                     2 execute, 3 next page
//   sw            in  SW_W-bit operand switches
//   sw_sext       in  1 = fill upper operand bits with ones, 0 = zeros
//   alu_porta/b   out registered operands A and B
//   alu_op        out registered opcode
//   alu_porto     in  ALU result
//   alu_negative, alu_overflow, alu_zero  in  ALU flags
//   led[17:0]     out {sticky_ovf, count[7:0], page[1:0], state[2:0], 0,
//                      neg, ovf, zero}
//   hex           out DATA_W/4 active-low digits, hex[i] = nibble i
//
// Build option: define ALU_TESTER_STICKY_EN to add a sticky overflow bit on
// led[17] (set by any latched overflow, cleared only by RST); otherwise
// led[17] is constant 0.
// -----------------------------------------------------------------------------
module alu_tester
  import alu_tester_pkg::*;
#(
  parameter int DATA_W     = 32,     // multiple of 4, at least 16
  parameter int SW_W       = 16,     // less than DATA_W
  parameter int OP_W       = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [3:0]                  key_n,
  input  logic [SW_W-1:0]             sw,
  input  logic                        sw_sext,
  output logic [DATA_W-1:0]           alu_porta,
  output logic [DATA_W-1:0]           alu_portb,
  output logic [OP_W-1:0]             alu_op,
  input  logic [DATA_W-1:0]           alu_porto,
  input  logic                        alu_negative,
  input  logic                        alu_overflow,
  input  logic                        alu_zero,
  output logic [17:0]                 led,
  output logic [DATA_W/4-1:0][6:0]    hex
);

  localparam int FILL_W   = DATA_W - SW_W;
  localparam int DIGITS   = DATA_W / 4;

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_evt;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_key_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .key_n (key_n[gi]),
        .press (key_evt[gi])
      );
    end
  endgenerate

  // Single winning event per cycle: execute > capture > next op > page.
  logic evt_exec;
  logic evt_cap;
  logic evt_op;
  logic evt_page;

  always_comb begin
    evt_exec = key_evt[KEY_EXECUTE];
    evt_cap  = key_evt[KEY_CAPTURE] && !evt_exec;
    evt_op   = key_evt[KEY_NEXT_OP] && !evt_exec && !key_evt[KEY_CAPTURE];
    evt_page = key_evt[KEY_PAGE]    && !evt_exec && !key_evt[KEY_CAPTURE]
                                    && !key_evt[KEY_NEXT_OP];
  end

  // The fill bit is sw_sext itself: ones when set, zeros when clear.
  logic [DATA_W-1:0] sw_ext;
  assign sw_ext = {{FILL_W{sw_sext}}, sw};

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_t            state_reg,  state_next;
  page_t             page_reg,   page_next;
  logic [DATA_W-1:0] a_reg,      a_next;
  logic [DATA_W-1:0] b_reg,      b_next;
  logic [OP_W-1:0]   op_reg,     op_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic [2:0]        flags_reg,  flags_next;   // {negative, overflow, zero}
  logic [7:0]        count_reg,  count_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      page_reg   <= PAGE_RESULT;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      page_reg   <= page_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    page_next   = page_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    count_next  = count_reg;

    if (state_reg == ST_EXEC) begin
      // The ALU has had a full cycle on the registered operands; latch on
      // this edge. Any key event this cycle is dropped.
      result_next = alu_porto;
      flags_next  = {alu_negative, alu_overflow, alu_zero};
      count_next  = count_reg + 8'd1;
      state_next  = ST_SHOW;
    end else if (evt_exec) begin
      // An execute in IDLE/HAVE_A still wins priority and is simply dropped.
      if (state_reg == ST_READY || state_reg == ST_SHOW) begin
        state_next = ST_EXEC;
      end
    end else if (evt_cap) begin
      case (state_reg)
        ST_HAVE_A: begin
          b_next     = sw_ext;
          state_next = ST_READY;
        end
        default: begin
          // IDLE, READY and SHOW all (re)start with operand A.
          a_next     = sw_ext;
          state_next = ST_HAVE_A;
        end
      endcase
    end else if (evt_op) begin
      op_next = op_reg + 1'b1;
    end else if (evt_page) begin
      page_next = page_t'(page_reg + 2'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional sticky overflow
  // ---------------------------------------------------------------------------
  logic sticky_bit;

`ifdef ALU_TESTER_STICKY_EN
  logic sticky_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == ST_EXEC && alu_overflow) begin
      sticky_reg <= 1'b1;
    end
  end

  assign sticky_bit = sticky_reg;
`else
  assign sticky_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_porta = a_reg;
  assign alu_portb = b_reg;
  assign alu_op    = op_reg;

  assign led = {sticky_bit, count_reg, page_reg, state_reg, 1'b0, flags_reg};

  logic [DATA_W-1:0] page_val;

  always_comb begin
    page_val = '0;
    case (page_reg)
      PAGE_RESULT: page_val = result_reg;
      PAGE_A:      page_val = a_reg;
      PAGE_B:      page_val = b_reg;
      default:     page_val = {{(DATA_W-OP_W){1'b0}}, op_reg};
    endcase
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
      assign hex[gi] = SEG_TABLE[page_val[gi*4 +: 4]];
    end
  endgenerate

endmodule

// File: tb/tb_alu_tester.sv
// -----------------------------------------------------------------------------
// tb_alu_tester
// Directed bench for alu_tester with DEB_CYCLES = 4 and a small behavioural
// ALU: op 0 = A+B, op 1 = low word of A*B (overflow when the high word is
// non-zero), op 2 = A-B, others pass A. negative = msb, zero = result == 0.
// -----------------------------------------------------------------------------
module tb_alu_tester;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int OP_W   = 4;

`ifdef ALU_TESTER_STICKY_EN
  localparam logic STICKY_EXP = 1'b1;
`else
  localparam logic STICKY_EXP = 1'b0;
`endif

  logic                     CLK;
  logic                     RST;
  logic [3:0]               key_n;
  logic [SW_W-1:0]          sw;
  logic                     sw_sext;
  logic [DATA_W-1:0]        alu_porta;
  logic [DATA_W-1:0]        alu_portb;
  logic [OP_W-1:0]          alu_op;
  logic [DATA_W-1:0]        alu_porto;
  logic                     alu_negative;
  logic                     alu_overflow;
  logic                     alu_zero;
  logic [17:0]              led;
  logic [DATA_W/4-1:0][6:0] hex;

  alu_tester #(
    .DATA_W     (DATA_W),
    .SW_W       (SW_W),
    .OP_W       (OP_W),
    .DEB_CYCLES (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .key_n        (key_n),
    .sw           (sw),
    .sw_sext      (sw_sext),
    .alu_porta    (alu_porta),
    .alu_portb    (alu_portb),
    .alu_op       (alu_op),
    .alu_porto    (alu_porto),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .led          (led),
    .hex          (hex)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External ALU model.
  logic [63:0] prod;
  always_comb begin
    prod = {32'd0, alu_porta} * {32'd0, alu_portb};
    case (alu_op)
      4'd0:    alu_porto = alu_porta + alu_portb;
      4'd1:    alu_porto = prod[31:0];
      4'd2:    alu_porto = alu_porta - alu_portb;
      default: alu_porto = alu_porta;
    endcase
    alu_overflow = (alu_op == 4'd1) && (prod[63:32] != 32'd0);
    alu_negative = alu_porto[31];
    alu_zero     = (alu_porto == 32'd0);
  end

  // Counts cycles spent in EXEC (led[6:4] = 100).
  int exec_total = 0;
  always @(negedge CLK) begin
    if (!RST && led[6:4] == 3'b100) exec_total++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected display for a 32-bit value, from the tb's own segment table.
  function automatic logic [55:0] hex_of(input logic [31:0] v);
    logic [6:0] seg [16];
    logic [55:0] r;
    seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = seg[v[i*4 +: 4]];
    return r;
  endfunction

  task automatic press(input logic [3:0] mask);
    key_n = ~mask;
    repeat (10) @(negedge CLK);
    key_n = 4'hF;
    repeat (6) @(negedge CLK);
    $display("press keys=%b state=%b op=%0d A=%h B=%h", mask, led[6:4], alu_op, alu_porta, alu_portb);
  endtask

  task automatic capture(input logic [15:0] v, input logic s);
    sw      = v;
    sw_sext = s;
    press(4'b0001);
  endtask

  int  exec_base;
  bit  seen;

  initial begin
    RST     = 1'b1;
    key_n   = 4'hF;
    sw      = '0;
    sw_sext = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset state.
    check("rst_led", 64'(led), 64'h0);
    check("rst_hex", 64'(hex), 64'(hex_of(32'h0)));
    check("rst_a",   64'(alu_porta), 64'h0);
    check("rst_op",  64'(alu_op), 64'h0);

    // 5 + 3 with op 0.
    capture(16'h0005, 1'b0);
    check("cap_a",       64'(alu_porta), 64'h5);
    check("st_have_a",   64'(led[6:4]), 64'b001);
    capture(16'h0003, 1'b0);
    check("cap_b",       64'(alu_portb), 64'h3);
    check("st_ready",    64'(led[6:4]), 64'b010);
    exec_base = exec_total;
    press(4'b0100);
    check("exec_cycles", 64'(exec_total - exec_base), 64'd1);
    check("st_show",     64'(led[6:4]), 64'b011);
    check("hex0_8",      64'(hex[0]), 64'h00);
    check("hex_res8",    64'(hex), 64'(hex_of(32'h8)));
    check("count1",      64'(led[16:9]), 64'd1);
    check("flags_add",   64'(led[2:0]), 64'b000);

    // Page 1 shows A.
    press(4'b1000);
    check("page1",       64'(led[8:7]), 64'd1);
    check("hex_a5",      64'(hex), 64'(hex_of(32'h5)));

    // Fill modes.
    capture(16'hFFFF, 1'b1);
    check("sext_a",      64'(alu_porta), 64'hFFFF_FFFF);
    check("hex_a_sext",  64'(hex), 64'(hex_of(32'hFFFF_FFFF)));
    capture(16'h0001, 1'b0);
    capture(16'hFFFF, 1'b0);
    check("zext_a",      64'(alu_porta), 64'h0000_FFFF);
    check("reload_st",   64'(led[6:4]), 64'b001);
    capture(16'h0002, 1'b0);
    check("b2",          64'(alu_portb), 64'h2);

    // Execute and capture together: execute wins, capture dropped.
    exec_base = exec_total;
    press(4'b0101);
    check("dual_exec",   64'(exec_total - exec_base), 64'd1);
    check("dual_a",      64'(alu_porta), 64'h0000_FFFF);
    check("dual_b",      64'(alu_portb), 64'h2);
    check("dual_st",     64'(led[6:4]), 64'b011);
    check("count2",      64'(led[16:9]), 64'd2);

    // Page cycling 1 -> 2 -> 3 -> 0.
    press(4'b1000);
    check("page2_hex",   64'(hex), 64'(hex_of(32'h2)));
    press(4'b1000);
    check("page3",       64'(led[8:7]), 64'd3);
    check("page3_hex",   64'(hex), 64'(hex_of(32'h0)));
    press(4'b1000);
    check("page0_hex",   64'(hex), 64'(hex_of(32'h0001_0001)));

    // 3-cycle glitch on key0: no event.
    key_n[0] = 1'b0;
    repeat (3) @(negedge CLK);
    key_n[0] = 1'b1;
    repeat (10) @(negedge CLK);
    check("glitch_st",   64'(led[6:4]), 64'b011);
    check("glitch_a",    64'(alu_porta), 64'h0000_FFFF);

    // Opcode wrap, result retained.
    for (int i = 0; i < 15; i++) press(4'b0010);
    check("op15",        64'(alu_op), 64'd15);
    press(4'b0010);
    check("op_wrap",     64'(alu_op), 64'd0);
    check("op_keep_res", 64'(hex), 64'(hex_of(32'h0001_0001)));

    // Execute ignored in HAVE_A.
    capture(16'hFFFF, 1'b1);
    exec_base = exec_total;
    press(4'b0100);
    check("ign_exec",    64'(exec_total - exec_base), 64'd0);
    check("ign_st",      64'(led[6:4]), 64'b001);
    check("ign_count",   64'(led[16:9]), 64'd2);
    capture(16'hFFFF, 1'b1);

    // op 1 multiply: overflow.
    press(4'b0010);
    press(4'b0100);
    check("mul_res",     64'(hex), 64'(hex_of(32'h1)));
    check("mul_flags",   64'(led[2:0]), 64'b010);
    check("mul_sticky",  64'(led[17]), 64'(STICKY_EXP));
    check("count3",      64'(led[16:9]), 64'd3);

    // op 2 subtract from SHOW: zero, clean result.
    press(4'b0010);
    press(4'b0100);
    check("zero_flags",  64'(led[2:0]), 64'b001);
    check("zero_sticky", 64'(led[17]), 64'(STICKY_EXP));
    check("count4",      64'(led[16:9]), 64'd4);

    // 1 - 2: negative.
    capture(16'h0001, 1'b0);
    capture(16'h0002, 1'b0);
    press(4'b0100);
    check("neg_flags",   64'(led[2:0]), 64'b100);
    check("neg_res",     64'(hex), 64'(hex_of(32'hFFFF_FFFF)));
    check("count5",      64'(led[16:9]), 64'd5);

    // RST in the middle of EXEC.
    key_n[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (led[6:4] == 3'b100) seen = 1'b1;
    end
    check("exec_seen",   64'(seen), 64'd1);
    RST = 1'b1;
    #1;
    key_n = 4'hF;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    $display("reset mid-exec state=%b led=%h", led[6:4], led);
    check("abort_led",   64'(led), 64'h0);
    check("abort_hex",   64'(hex), 64'(hex_of(32'h0)));
    check("abort_a",     64'(alu_porta), 64'h0);
    check("abort_b",     64'(alu_portb), 64'h0);
    check("abort_op",    64'(alu_op), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
